// File: rtl/hearts_meter.sv
// Life-meter sprite overlay: a row of MAX_HEARTS heart icons, full or empty, with a
// per-frame sampled count and a blink animation on the hearts that were just lost.
module hearts_meter #(
  parameter int          MAX_HEARTS   = 3,
  parameter int          X0           = 240,
  parameter int          Y0           = 16,
  parameter int          SPRITE_W     = 16,
  parameter int          SPRITE_H     = 16,
  parameter logic [11:0] KEY_COLOR    = 12'h6DE,
  parameter int          BLINK_FRAMES = 32,
  parameter int          BLINK_PERIOD = 4,
  parameter int          ROM_LATENCY  = 1,
  localparam int         CW           = $clog2(MAX_HEARTS + 1),
  localparam int         ROW_W        = $clog2(2 * SPRITE_H),
  localparam int         COL_W        = $clog2(SPRITE_W)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [9:0]       x,
  input  logic [9:0]       y,
  input  logic             frame_tick,
  input  logic [CW-1:0]    num_hearts,
  output logic [ROW_W-1:0] rom_row,
  output logic [COL_W-1:0] rom_col,
  input  logic [11:0]      rom_data,
  output logic [11:0]      color_data,
  output logic             hearts_on,
  output logic             animating
);

  localparam int            FW    = $clog2(BLINK_FRAMES + 1);
  localparam logic [10:0]   X_LO  = 11'(X0);
  localparam logic [10:0]   X_HI  = 11'(X0 + MAX_HEARTS * SPRITE_W);
  localparam logic [10:0]   Y_LO  = 11'(Y0);
  localparam logic [10:0]   Y_HI  = 11'(Y0 + SPRITE_H);
  localparam logic [CW-1:0] MAX_N = CW'(MAX_HEARTS);

  typedef enum logic {IDLE, BLINK} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   shown_q, shown_d;
  logic [CW-1:0]   lo_q, lo_d;
  logic [CW-1:0]   hi_q, hi_d;
  logic [FW-1:0]   fcnt_q, fcnt_d, fcnt_inc;
  logic [CW-1:0]   n;

  assign n        = (num_hearts > MAX_N) ? MAX_N : num_hearts;
  assign fcnt_inc = fcnt_q + FW'(1);

  // NOTE: every variable gets its hold value first, so no path leaves it unassigned (no latch).
  always_comb begin
    state_d = state_q;
    shown_d = shown_q;
    lo_d    = lo_q;
    hi_d    = hi_q;
    fcnt_d  = fcnt_q;
    if (frame_tick) begin
      case (state_q)
        IDLE: begin
          shown_d = n;
          if (n < shown_q) begin
            lo_d    = n;
            hi_d    = shown_q;
            fcnt_d  = '0;
            state_d = BLINK;
          end
        end
        BLINK: begin
          if (n < shown_q) begin
            // A further hit widens the range downwards and restarts the timer.
            lo_d    = n;
            fcnt_d  = '0;
            shown_d = n;
          end else if (n > shown_q) begin
            shown_d = n;
            state_d = IDLE;
          end else begin
            fcnt_d = fcnt_inc;
            if (fcnt_inc == FW'(BLINK_FRAMES)) state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      shown_q <= MAX_N;
      lo_q    <= '0;
      hi_q    <= '0;
      fcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      shown_q <= shown_d;
      lo_q    <= lo_d;
      hi_q    <= hi_d;
      fcnt_q  <= fcnt_d;
    end
  end

  logic [10:0] x_ext, y_ext, dx, slot;
  logic [ROW_W-2:0] r;
  logic in_region, blink_show, draw_full;

  assign x_ext     = {1'b0, x};
  assign y_ext     = {1'b0, y};
  assign dx        = x_ext - X_LO;
  assign slot      = dx >> COL_W;
  assign r         = y[ROW_W-2:0] - Y_LO[ROW_W-2:0];
  assign in_region = (x_ext >= X_LO) && (x_ext < X_HI) && (y_ext >= Y_LO) && (y_ext < Y_HI);

  // Lost hearts start the blink in the full phase.
  assign blink_show = (state_q == BLINK) && (slot >= 11'(lo_q)) && (slot < 11'(hi_q))
                   && (((32'(fcnt_q) / BLINK_PERIOD) % 2) == 0);
  assign draw_full  = (slot < 11'(shown_q)) || blink_show;

  // The empty sprite sits SPRITE_H rows below the full one, so the MSB selects it.
  always_comb begin
    rom_row = '0;
    rom_col = '0;
    if (in_region) begin
      rom_col = dx[COL_W-1:0];
      rom_row = {~draw_full, r};
    end
  end

  logic [ROM_LATENCY-1:0] region_pipe;
  logic                   pix_on;

  assign pix_on = region_pipe[ROM_LATENCY-1] && (rom_data != KEY_COLOR);

  // NOTE: the region delay line is a handful of flops, so it is reset along with the outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      region_pipe <= '0;
      hearts_on   <= 1'b0;
      color_data  <= '0;
    end else begin
      region_pipe[0] <= in_region;
      for (int i = 1; i < ROM_LATENCY; i++) region_pipe[i] <= region_pipe[i-1];
      hearts_on  <= pix_on;
      color_data <= pix_on ? rom_data : 12'h000;
    end
  end

  assign animating = (state_q == BLINK);

endmodule

// File: tb/tb_hearts_meter.sv
// Randomised scoreboard bench for hearts_meter: a frame-level reference model predicts
// every pixel; a monitor compares DUT outputs as they emerge from the pipeline.
module tb_hearts_meter;

  localparam int          MAXH = 3;
  localparam int          XL   = 240;
  localparam int          YT   = 16;
  localparam int          SW   = 16;
  localparam int          SH   = 16;
  localparam logic [11:0] KEY  = 12'h6DE;
  localparam int          BF   = 32;
  localparam int          BP   = 4;
  localparam int          RL   = 1;
  localparam int          LAT  = RL + 1;

  logic        clk = 1'b0;
  logic        reset;
  logic [9:0]  x, y;
  logic        frame_tick;
  logic [1:0]  num_hearts;
  logic [4:0]  rom_row;
  logic [3:0]  rom_col;
  logic [11:0] rom_data;
  logic [11:0] color_data;
  logic        hearts_on;
  logic        animating;

  hearts_meter #(
    .MAX_HEARTS(MAXH), .X0(XL), .Y0(YT), .SPRITE_W(SW), .SPRITE_H(SH), .KEY_COLOR(KEY),
    .BLINK_FRAMES(BF), .BLINK_PERIOD(BP), .ROM_LATENCY(RL)
  ) dut (
    .clk(clk), .reset(reset), .x(x), .y(y), .frame_tick(frame_tick), .num_hearts(num_hearts),
    .rom_row(rom_row), .rom_col(rom_col), .rom_data(rom_data), .color_data(color_data),
    .hearts_on(hearts_on), .animating(animating)
  );

  always #5 clk = ~clk;

  // Sprite ROM: column 1 is transparent; every other texel encodes its own address.
  function automatic logic [11:0] rom_fn(input logic [4:0] row, input logic [3:0] col);
    return (col == 4'd1) ? KEY : {3'b001, row, col};
  endfunction

  logic [11:0] rom_pipe [RL];
  always @(posedge clk) begin
    rom_pipe[0] <= rom_fn(rom_row, rom_col);
    for (int i = 1; i < RL; i++) rom_pipe[i] <= rom_pipe[i-1];
  end
  assign rom_data = rom_pipe[RL-1];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  // Frame-level model: hit_tick marks the frame of the most recent loss.
  int m_shown = MAXH;
  int m_lo = 0, m_hi = 0;
  bit m_blink = 0;
  int tick_no = 0, hit_tick = 0;

  task automatic model_reset();
    m_shown = MAXH;
    m_blink = 0;
  endtask

  task automatic model_tick(input int raw);
    int nh;
    nh = (raw > MAXH) ? MAXH : raw;
    tick_no++;
    if (!m_blink) begin
      if (nh < m_shown) begin
        m_lo = nh; m_hi = m_shown; hit_tick = tick_no; m_blink = 1;
      end
      m_shown = nh;
    end else if (nh < m_shown) begin
      m_lo = nh; hit_tick = tick_no; m_shown = nh;
    end else if (nh > m_shown) begin
      m_shown = nh; m_blink = 0;
    end else if (tick_no - hit_tick >= BF) begin
      m_blink = 0;
    end
  endtask

  typedef struct {
    int          cyc;
    logic        on;
    logic [11:0] color;
    logic        anim;
  } exp_t;

  exp_t exp_q[$];

  function automatic exp_t predict(input int px, input int py);
    exp_t e;
    int k, c, row;
    bit full;
    logic [11:0] texel;
    e.cyc = cyc; e.on = 1'b0; e.color = 12'h000; e.anim = m_blink;
    if (px >= XL && px < XL + MAXH * SW && py >= YT && py < YT + SH) begin
      k = (px - XL) / SW;
      c = (px - XL) % SW;
      full = (k < m_shown) ||
             (m_blink && k >= m_lo && k < m_hi && (((tick_no - hit_tick) / BP) % 2 == 0));
      row = (py - YT) + (full ? 0 : SH);
      texel = (c == 1) ? KEY : (12'h200 | 12'(row << 4) | 12'(c));
      e.on = (texel != KEY);
      e.color = e.on ? texel : 12'h000;
    end
    return e;
  endfunction

  always @(negedge clk) begin
    if (!reset) begin
      while (exp_q.size() > 0 && exp_q[0].cyc + LAT < cyc) begin
        check("pixel_missed", 32'(cyc), 32'(exp_q[0].cyc + LAT));
        void'(exp_q.pop_front());
      end
      if (exp_q.size() > 0 && exp_q[0].cyc + LAT == cyc) begin
        exp_t e;
        e = exp_q.pop_front();
        check("hearts_on", 32'(hearts_on), 32'(e.on));
        check("color_data", 32'(color_data), 32'(e.color));
        check("animating_px", 32'(animating), 32'(e.anim));
      end
    end
  end

  // num_hearts is scrambled on every pixel; only frame_tick may latch it.
  task automatic drive_px(input int px, input int py);
    @(posedge clk); #1;
    x = 10'(px);
    y = 10'(py);
    num_hearts = 2'($urandom);
    exp_q.push_back(predict(px, py));
  endtask

  task automatic scan_random(input int count);
    for (int i = 0; i < count; i++)
      drive_px(int'($urandom_range(300, 228)), int'($urandom_range(36, 10)));
  endtask

  task automatic drain();
    repeat (LAT + 1) @(posedge clk);
    #1;
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic tick(input int raw);
    @(posedge clk); #1;
    num_hearts = 2'(raw);
    frame_tick = 1'b1;
    @(posedge clk); #1;
    frame_tick = 1'b0;
    model_tick(raw & 3);
    check("animating_tick", 32'(animating), 32'(m_blink));
  endtask

  task automatic reset_pulse();
    @(posedge clk); #1;
    reset = 1'b1;
    #1;
    check("rst_animating", 32'(animating), 32'd0);
    check("rst_hearts_on", 32'(hearts_on), 32'd0);
    check("rst_color", 32'(color_data), 32'd0);
    model_reset();
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: run did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1; x = '0; y = '0; frame_tick = 1'b0; num_hearts = '0;
    repeat (3) @(posedge clk);
    #1;
    check("init_hearts_on", 32'(hearts_on), 32'd0);
    check("init_color", 32'(color_data), 32'd0);
    check("init_animating", 32'(animating), 32'd0);
    reset = 1'b0;

    // Static render with two hearts, full row sweep plus region edges.
    tick(2);
    for (int px = XL - 1; px <= XL + MAXH * SW; px++) drive_px(px, 20);
    drive_px(250, YT - 1); drive_px(250, YT); drive_px(250, YT + SH - 1); drive_px(250, YT + SH);
    drain();

    // Single loss 3 -> 1, full blink lifetime.
    tick(3);
    scan_random(10); drain();
    tick(1);
    for (int f = 0; f < BF; f++) begin
      scan_random(12); drain();
      tick(1);
    end
    scan_random(12); drain();

    // Second hit mid-blink restarts the timer and widens the range.
    tick(3);
    tick(2);
    for (int f = 0; f < 9; f++) begin
      scan_random(6); drain(); tick(2);
    end
    tick(0);
    for (int f = 0; f < BF; f++) begin
      scan_random(6); drain(); tick(0);
    end
    scan_random(10); drain();

    // Heal three frames into a blink.
    tick(3);
    tick(1); tick(1); tick(1);
    scan_random(10); drain();
    tick(3);
    scan_random(10); drain();

    // Over-range request and reset during blink.
    tick(7);
    scan_random(10); drain();
    tick(0);
    scan_random(10); drain();
    reset_pulse();
    scan_random(20); drain();

    // Random sequence of frame updates.
    for (int i = 0; i < 60; i++) begin
      tick(int'($urandom_range(0, 7)));
      scan_random(8); drain();
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/hearts_meter.md
# hearts_meter

Parametrised life-meter sprite overlay for the VGA pixel pipeline. Draws MAX_HEARTS heart icons in a row, each full or empty, from a sprite ROM held outside the block. It samples the heart count once per frame so the meter never tears mid-frame. When hearts are lost, the lost hearts blink for a set number of frames before settling to empty. Outputs are registered and aligned to the ROM latency; the pixel mux uses hearts_on/color_data exactly like the other sprite layers.

## Interface
- MAX_HEARTS, 3: number of heart slots, 1..8
- X0, 240: left pixel column of slot 0
- Y0, 16: top pixel row of the meter
- SPRITE_W, 16: heart width in pixels, power of 2
- SPRITE_H, 16: heart height in pixels, power of 2
- KEY_COLOR, 12'h6DE: sprite background colour, never drawn
- BLINK_FRAMES, 32: blink duration in frames, ≥1
- BLINK_PERIOD, 4: frames per blink half-phase, ≥1
- ROM_LATENCY, 1: sprite ROM read latency in cycles, ≥1
- CW is derived: $clog2(MAX_HEARTS+1). It is not a parameter.

Ports:
- clk  in  1  pixel-domain clock
- reset  in  1  asynchronous, active-high
- x, y  in  10 each  VGA pixel coordinates, valid every cycle
- frame_tick  in  1  one-cycle pulse once per frame, during vblank
- num_hearts  in  CW  requested full-heart count; values above MAX_HEARTS are clamped to MAX_HEARTS
- rom_row  out  $clog2(2*SPRITE_H)  ROM row index
  - rows 0..SPRITE_H-1 hold the full heart
  - rows SPRITE_H..2*SPRITE_H-1 hold the empty heart
- rom_col  out  $clog2(SPRITE_W)  ROM column index
- rom_data  in  12  ROM colour, valid ROM_LATENCY cycles after the address
- color_data  out  12  registered pixel colour
- hearts_on  out  1  registered; high when the meter covers the pixel
- animating  out  1  high while in BLINK

## Operation
- Region: x in [X0, X0+MAX_HEARTS*SPRITE_W) and y in [Y0, Y0+SPRITE_H).
- Slot k = (x-X0)>>log2(SPRITE_W). col = (x-X0) mod SPRITE_W. r = y-Y0.
- Address (combinational from x/y):
  - rom_col = col
  - rom_row = r if slot k is drawn full, else r+SPRITE_H
  - outside the region, rom_row = 0 and rom_col = 0
- Registered state:
  - shown: CW bits, reset value MAX_HEARTS
  - lo, hi: blink range [lo, hi)
  - fcnt: frames elapsed in BLINK
  - state: IDLE or BLINK
- On frame_tick, with n = clamp(num_hearts):
  - IDLE, n < shown: lo←n, hi←shown, fcnt←0, shown←n, go to BLINK.
  - IDLE, n ≥ shown: shown←n.
  - BLINK, n < shown: lo←n, hi unchanged, fcnt←0, shown←n. Stay in BLINK; the timer restarts.
  - BLINK, n > shown: shown←n, go to IDLE. A heal cancels the blink.
  - BLINK, n == shown: fcnt←fcnt+1. When fcnt+1 == BLINK_FRAMES, go to IDLE.
- Slot k is drawn full when either:
  - k < shown, or
  - state==BLINK, lo ≤ k < hi, and (fcnt/BLINK_PERIOD) is even, i.e. lost hearts show full first.
- The full/empty decision uses shown and the blink state as they are at address time. It changes only on frame_tick, which keeps the meter stable across the visible frame.
- Pixel output: hearts_on = region_d && (rom_data != KEY_COLOR). color_data = rom_data when hearts_on, else 0.
- animating = (state==BLINK).

## Timing
- Latency: x/y presented in cycle t → hearts_on/color_data valid in cycle t+ROM_LATENCY+1.
  - The region flag is delayed ROM_LATENCY cycles to line up with rom_data.
  - The output register adds one further cycle.
- frame_tick is processed in the cycle it is high. num_hearts is sampled only in that cycle; changes between ticks are ignored.
- Reset asserted, including mid-blink: immediately shown=MAX_HEARTS, state=IDLE, fcnt=0, hearts_on=0, color_data=0, animating=0. The delay pipeline is cleared.
- First valid pixel: ROM_LATENCY+1 cycles after reset deasserts.
- Boundaries:
  - num_hearts=0 → every slot is empty.
  - Losing all hearts at once → lo=0, hi=MAX_HEARTS, so every slot blinks.
  - BLINK_FRAMES=1 → BLINK lasts exactly one frame.
  - x = X0+MAX_HEARTS*SPRITE_W-1 is inside the region. X0+MAX_HEARTS*SPRITE_W is outside.

## Test plan
- Static render (defaults): reset, num_hearts=2, one frame_tick, then scan x=240..287 at y=20. ROM model: full rows 0x0F00, empty rows 0x00F0, col 0 = KEY_COLOR. Required: slots 0-1 give 0x0F00, slot 2 gives 0x00F0, col 0 of every slot gives hearts_on=0, and output latency is 2 cycles.
- Blink: hold 3, then drop to 1 at tick T. Required: animating=1 from T. Slots 1-2 are full for frames 0-3, empty for 4-7, and alternate that way until frame 31. IDLE follows after 32 ticks, with slots 1-2 empty.
- Second hit mid-blink: 3→2 at tick T, then 2→0 at T+10. Required: lo=0, hi=3, the timer restarts, and the blink ends 32 ticks after T+10.
- Heal mid-blink: 3→1, then 1→3 three ticks later. Required: state goes to IDLE at that tick and all slots are full.
- Clamp and tearing: num_hearts=7 with MAX_HEARTS=3 → 3 full. A change of num_hearts mid-frame without frame_tick → output unchanged.
- Reset during BLINK: assert reset for 1 cycle. Required: animating=0 and hearts_on=0 immediately, then shown=3 is drawn.
